// File: rtl/htpv_defs_pkg.sv
// ---------------------------------------------------------------------------
// htpv_defs_pkg
// Shared definitions for the HTPV descreener: frame geometry, the
// count-to-gray lookup table and the controller state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package htpv_defs_pkg;

    localparam int N_ROWS = 6;
    localparam int N_COLS = 8;
    localparam int N_PIX  = N_ROWS * N_COLS;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    // round(count * 255 / 9) for count = 0..9
    localparam logic [7:0] GRAY_LUT [0:9] = '{
        8'd0,   8'd28,  8'd57,  8'd85,  8'd113,
        8'd142, 8'd170, 8'd198, 8'd227, 8'd255
    };

    // A clamped 3x3 count never exceeds 9; saturate anyway so the index
    // can never leave the table.
    function automatic logic [7:0] gray_of(input logic [3:0] count);
        if (count > 4'd9) begin
            return GRAY_LUT[9];
        end
        return GRAY_LUT[count];
    endfunction

endpackage

// File: rtl/htpv_window_count.sv
// ---------------------------------------------------------------------------
// htpv_window_count
// Combinational popcount of the 3x3 window centred on (row, col) with
// edge replication: neighbour coordinates are clamped into the frame, so
// border pixels count their own edge cells more than once.
// Ports:
//   frame  in  N_PIX  frame bits, index row*N_COLS+col, col 0 = leftmost
//   row    in  3      zero-based row of the window centre
//   col    in  3      zero-based column of the window centre
//   count  out 4      number of ones in the window, 0..9
// ---------------------------------------------------------------------------
module htpv_window_count
    import htpv_defs_pkg::*;
(
    input  logic [0:N_PIX-1] frame,
    input  logic [2:0]       row,
    input  logic [2:0]       col,
    output logic [3:0]       count
);

    always_comb begin
        int rr;
        int cc;
        logic [5:0] bit_idx;
        count   = '0;
        rr      = 0;
        cc      = 0;
        bit_idx = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = int'(row) + dr;
                cc = int'(col) + dc;
                if (rr < 0)       rr = 0;
                if (rr >= N_ROWS) rr = N_ROWS - 1;
                if (cc < 0)       cc = 0;
                if (cc >= N_COLS) cc = N_COLS - 1;
                bit_idx = 6'(rr * N_COLS + cc);
                count   = count + {3'b000, frame[bit_idx]};
            end
        end
    end

endmodule

// File: rtl/htpv_descreener.sv
// ---------------------------------------------------------------------------
// htpv_descreener
// Loads one halftoned frame (6 rows x 8 bits, 1 = white), then streams 48
// reconstructed 8-bit gray pixels in raster order. Each pixel is the LUT
// value of its clamped 3x3 window popcount. All outputs are registered.
//
// state | meaning
// ------+--------------------------------------------------------------
// LOAD  | row_ready=1, rows written to buffer row row_cnt
// EMIT  | row_ready=0, pixels 0..47 presented on the valid/ready link
//
// Ports:
//   clock      in   1       single clock, posedge
//   reset      in   1       synchronous, active-high
//   row_in     in   N_COLS  HTPV row, bit 1 = leftmost pixel
//   row_valid  in   1       row_in valid
//   row_ready  out  1       block accepts a row
//   pixel_out  out  8       reconstructed gray value
//   pix_valid  out  1       pixel_out valid
//   pix_ready  in   1       consumer accepts pixel_out
//   pix_last   out  1       high with the final pixel of the frame
// ---------------------------------------------------------------------------
module htpv_descreener
    import htpv_defs_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [1:N_COLS] row_in,
    input  logic            row_valid,
    output logic            row_ready,
    output logic [7:0]      pixel_out,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic            pix_last
);

    state_t           state, state_nxt;
    logic [2:0]       row_cnt, row_cnt_nxt;
    logic [5:0]       pix_idx, pix_idx_nxt;
    logic [0:N_PIX-1] frame, frame_nxt;
    logic [7:0]       pixel_nxt;
    logic             valid_nxt;
    logic             last_nxt;
    logic             row_ready_nxt;
    logic             row_accept;
    logic             pix_accept;
    logic [5:0]       win_idx;
    logic [2:0]       win_row;
    logic [2:0]       win_col;
    logic [3:0]       win_count;

    assign row_accept = (state == LOAD) && row_valid && row_ready;
    assign pix_accept = (state == EMIT) && pix_valid && pix_ready;

    // The incoming row is merged before the window sees the frame, so the
    // first pixel can be registered on the same edge that takes row 6.
    always_comb begin
        frame_nxt = frame;
        if (row_accept) begin
            frame_nxt[6'(row_cnt) * 6'(N_COLS) +: N_COLS] = row_in;
        end
    end

    // Window looks one pixel ahead: the value computed now is the one that
    // will be presented after the current transfer.
    always_comb begin
        win_idx = '0;
        if (state == EMIT) begin
            win_idx = pix_idx + 6'd1;
        end
        win_row = 3'(win_idx / 6'(N_COLS));
        win_col = 3'(win_idx % 6'(N_COLS));
    end

    htpv_window_count u_window (
        .frame (frame_nxt),
        .row   (win_row),
        .col   (win_col),
        .count (win_count)
    );

    always_comb begin
        state_nxt   = state;
        row_cnt_nxt = row_cnt;
        pix_idx_nxt = pix_idx;
        pixel_nxt   = pixel_out;
        valid_nxt   = pix_valid;
        last_nxt    = pix_last;
        case (state)
            LOAD: begin
                if (row_accept) begin
                    if (row_cnt == 3'(N_ROWS - 1)) begin
                        state_nxt   = EMIT;
                        row_cnt_nxt = '0;
                        pix_idx_nxt = '0;
                        pixel_nxt   = gray_of(win_count);
                        valid_nxt   = 1'b1;
                        last_nxt    = 1'b0;
                    end else begin
                        row_cnt_nxt = row_cnt + 3'd1;
                    end
                end
            end
            EMIT: begin
                if (pix_accept) begin
                    if (pix_idx == 6'(N_PIX - 1)) begin
                        state_nxt   = LOAD;
                        row_cnt_nxt = '0;
                        pix_idx_nxt = '0;
                        valid_nxt   = 1'b0;
                        last_nxt    = 1'b0;
                    end else begin
                        pix_idx_nxt = pix_idx + 6'd1;
                        pixel_nxt   = gray_of(win_count);
                        last_nxt    = (pix_idx_nxt == 6'(N_PIX - 1));
                    end
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
        row_ready_nxt = (state_nxt == LOAD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= LOAD;
            row_cnt   <= '0;
            pix_idx   <= '0;
            row_ready <= 1'b1;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            pixel_out <= '0;
        end else begin
            state     <= state_nxt;
            row_cnt   <= row_cnt_nxt;
            pix_idx   <= pix_idx_nxt;
            row_ready <= row_ready_nxt;
            pix_valid <= valid_nxt;
            pix_last  <= last_nxt;
            pixel_out <= pixel_nxt;
        end
    end

    // Buffer contents are don't-care after reset; no reset keeps it plain flops.
    always_ff @(posedge clock) begin
        frame <= frame_nxt;
    end

endmodule

// File: tb/tb_htpv_descreener.sv
// ---------------------------------------------------------------------------
// tb_htpv_descreener
// Directed self-checking bench for htpv_descreener. Inputs are driven and
// outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_htpv_descreener;

    logic       clock;
    logic       reset;
    logic [1:8] row_in;
    logic       row_valid;
    logic       row_ready;
    logic [7:0] pixel_out;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_last;

    int n_checks;
    int n_fail;

    htpv_descreener dut (
        .clock     (clock),
        .reset     (reset),
        .row_in    (row_in),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .pixel_out (pixel_out),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: clamped 3x3 count, gray by integer rounding of count*255/9.
    function automatic int ref_gray(input logic [7:0] f [6], input int row, input int col);
        int cnt;
        int rr;
        int cc;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = row + dr;
                cc = col + dc;
                rr = (rr < 1) ? 1 : ((rr > 6) ? 6 : rr);
                cc = (cc < 1) ? 1 : ((cc > 8) ? 8 : cc);
                cnt += int'(f[rr-1][8-cc]);
            end
        end
        return (cnt * 255 + 4) / 9;
    endfunction

    task automatic load_frame(input logic [7:0] f [6], input bit gaps);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < 6 && guard < 200) begin
            chk("pix_valid_load", int'(pix_valid), 0);
            if (gaps && $urandom_range(0, 2) == 0) begin
                row_valid = 1'b0;
                row_in    = 8'h00;
            end else begin
                row_valid = 1'b1;
                row_in    = f[i];
                if (row_ready) i++;
            end
            @(negedge clock);
            guard++;
        end
        row_valid = 1'b0;
        chk("rows_loaded", i, 6);
    endtask

    // Starts at a negedge with the frame loaded; returns at the negedge
    // after the last transfer (or at transfer stop_at when stop_at >= 0).
    task automatic collect_frame(input logic [7:0] f [6], input bit rand_ready,
                                 input int stop_at, output int ntrans,
                                 output logic [7:0] got [48]);
        int n;
        int guard;
        bit prev_stall;
        logic [7:0] held;
        logic held_last;
        n = 0;
        guard = 0;
        prev_stall = 1'b0;
        held = '0;
        held_last = 1'b0;
        for (int k = 0; k < 48; k++) got[k] = 8'hxx;
        while (n < 48 && guard < 3000) begin
            if (stop_at >= 0 && n == stop_at) break;
            pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                chk("stall_valid", int'(pix_valid), 1);
                chk("stall_pixel", int'(pixel_out), int'(held));
                chk("stall_last", int'(pix_last), int'(held_last));
            end
            prev_stall = 1'b0;
            if (pix_valid) begin
                chk("row_ready_emit", int'(row_ready), 0);
                if (pix_ready) begin
                    got[n] = pixel_out;
                    chk($sformatf("pixel_%0d", n), int'(pixel_out),
                        ref_gray(f, n / 8 + 1, n % 8 + 1));
                    chk($sformatf("pix_last_%0d", n), int'(pix_last), (n == 47) ? 1 : 0);
                    n++;
                end else begin
                    prev_stall = 1'b1;
                    held = pixel_out;
                    held_last = pix_last;
                end
            end
            @(negedge clock);
            guard++;
        end
        ntrans = n;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_pix_valid"}, int'(pix_valid), 0);
        chk({tag, "_row_ready"}, int'(row_ready), 1);
        chk({tag, "_pix_last"}, int'(pix_last), 0);
    endtask

    logic [7:0] f_ones  [6];
    logic [7:0] f_zeros [6];
    logic [7:0] f_dot   [6];
    logic [7:0] f_check [6];
    logic [7:0] f_mix   [6];
    logic [7:0] got     [48];
    int ntrans;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        row_in    = '0;
        row_valid = 1'b0;
        pix_ready = 1'b0;

        f_ones  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        f_zeros = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        f_dot   = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        f_check = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
        f_mix   = '{8'h96, 8'h3C, 8'hF0, 8'h0F, 8'h81, 8'h5A};

        repeat (3) @(negedge clock);
        check_idle("reset");
        chk("reset_pixel_out", int'(pixel_out), 0);
        reset = 1'b0;
        @(negedge clock);

        // 1: all ones, latency 1 to first pix_valid
        load_frame(f_ones, 1'b0);
        chk("first_valid_latency", int'(pix_valid), 1);
        chk("row_ready_after_load", int'(row_ready), 0);
        collect_frame(f_ones, 1'b0, -1, ntrans, got);
        chk("ones_count", ntrans, 48);
        chk("ones_first", int'(got[0]), 255);
        chk("ones_last", int'(got[47]), 255);
        check_idle("ones_end");

        // 2: all zeros, then all ones back to back
        load_frame(f_zeros, 1'b0);
        collect_frame(f_zeros, 1'b0, -1, ntrans, got);
        chk("zeros_count", ntrans, 48);
        chk("zeros_mid", int'(got[27]), 0);
        check_idle("zeros_end");
        load_frame(f_ones, 1'b0);
        collect_frame(f_ones, 1'b0, -1, ntrans, got);
        chk("ones2_count", ntrans, 48);
        chk("ones2_mid", int'(got[20]), 255);

        // 3: single white dot at (1,1)
        load_frame(f_dot, 1'b0);
        collect_frame(f_dot, 1'b0, -1, ntrans, got);
        chk("dot_r1c1", int'(got[0]), 113);
        chk("dot_r1c2", int'(got[1]), 57);
        chk("dot_r2c2", int'(got[9]), 28);
        chk("dot_r1c3", int'(got[2]), 0);
        chk("dot_r6c8", int'(got[47]), 0);

        // 4: checkerboard
        load_frame(f_check, 1'b0);
        collect_frame(f_check, 1'b0, -1, ntrans, got);
        chk("chk_r2c2", int'(got[9]), 142);
        chk("chk_r2c3", int'(got[10]), 113);
        chk("chk_r3c2", int'(got[17]), 113);
        chk("chk_r1c1", int'(got[0]), 142);
        chk("chk_r1c8", int'(got[7]), 113);
        chk("chk_r6c8", int'(got[47]), 142);

        // 5: random backpressure and gaps in the row stream
        for (int rep = 0; rep < 2; rep++) begin
            load_frame(f_mix, 1'b1);
            collect_frame(f_mix, 1'b1, -1, ntrans, got);
            chk("stall_frame_count", ntrans, 48);
            check_idle("stall_end");
        end

        // 6: reset during EMIT at pixel 20, then a fresh frame
        load_frame(f_check, 1'b0);
        collect_frame(f_check, 1'b0, 20, ntrans, got);
        chk("pre_reset_count", ntrans, 20);
        reset = 1'b1;
        pix_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check_idle("midreset");
        load_frame(f_mix, 1'b0);
        collect_frame(f_mix, 1'b1, -1, ntrans, got);
        chk("post_reset_count", ntrans, 48);
        check_idle("post_reset_end");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
